// File: rtl/riscv_div_pkg.sv
// riscv_div_pkg: shared encodings for the iterative RV32M divider.
//   - div_op_e    : DIV/DIVU/REM/REMU operation encodings (matches funct3[1:0]).
//   - div_state_e : divider FSM state encodings.
//   - XLEN        : native register width.
package riscv_div_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    DIV_OP_DIV  = 2'b00,
    DIV_OP_DIVU = 2'b01,
    DIV_OP_REM  = 2'b10,
    DIV_OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_FIX  = 2'b10
  } div_state_e;

endpackage

// File: rtl/riscv_div_step.sv
// riscv_div_step: one combinational radix-2 restoring division iteration.
//   rem_i, quo_i : partial remainder and dividend/quotient shift register
//   div_i        : divisor magnitude
//   rem_o, quo_o : values after shifting {rem,quo} left and trial subtracting
module riscv_div_step
  import riscv_div_pkg::*;
#(
  parameter int WIDTH = XLEN
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] div_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  // The shifted remainder needs WIDTH+1 bits; the MSB of the difference
  // is the borrow and tells whether the trial subtraction fits.
  logic [WIDTH:0] trial;

  always_comb begin
    trial = {rem_i, quo_i[WIDTH-1]} - {1'b0, div_i};
    if (!trial[WIDTH]) begin
      rem_o = trial[WIDTH-1:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b1};
    end else begin
      rem_o = {rem_i[WIDTH-2:0], quo_i[WIDTH-1]};
      quo_o = {quo_i[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/riscv_div_iter.sv
// riscv_div_iter: iterative radix-2 restoring divider for RV32M
// DIV/DIVU/REM/REMU, sitting in EX beside the ALU.
//   clk, rst_n   : clock, asynchronous active-low reset
//   start        : request pulse, accepted only when idle and not busy
//   op           : 00=DIV 01=DIVU 10=REM 11=REMU
//   src_a, src_b : dividend, divisor
//   flush        : abort any operation in progress (wins over start)
//   busy         : stall request, high from accept through the done cycle
//   done         : one-cycle result-valid pulse
//   res          : quotient/remainder, held until the next done
// Optional macro RISCV_DIV_EARLY_OUT_EN: divide-by-zero, signed overflow
// and |a|<|b| skip the iteration and complete in the cycle after start.
module riscv_div_iter
  import riscv_div_pkg::*;
#(
  parameter int WIDTH = XLEN,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] res
);

  div_state_e       state_q, state_d;
  div_op_e          op_q, op_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             negq_q, negq_d;
  logic             negr_q, negr_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             done_q, done_d;

  div_op_e          op_in;
  logic             signed_op;
  logic             sign_a, sign_b;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH-1:0] step_rem, step_quo;
  logic [WIDTH-1:0] quo_fix, rem_fix;
  logic             is_rem_q;

  riscv_div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .div_i (div_q),
    .rem_o (step_rem),
    .quo_o (step_quo)
  );

  assign op_in     = div_op_e'(op);
  assign signed_op = (op_in == DIV_OP_DIV) || (op_in == DIV_OP_REM);
  assign sign_a    = signed_op & src_a[WIDTH-1];
  assign sign_b    = signed_op & src_b[WIDTH-1];
  assign abs_a     = sign_a ? (~src_a + 1'b1) : src_a;
  assign abs_b     = sign_b ? (~src_b + 1'b1) : src_b;

  assign is_rem_q  = (op_q == DIV_OP_REM) || (op_q == DIV_OP_REMU);
  assign quo_fix   = negq_q ? (~quo_q + 1'b1) : quo_q;
  assign rem_fix   = negr_q ? (~rem_q + 1'b1) : rem_q;

`ifdef RISCV_DIV_EARLY_OUT_EN
  logic             early_hit;
  logic [WIDTH-1:0] early_res;
  logic             is_rem_in;

  assign is_rem_in = (op_in == DIV_OP_REM) || (op_in == DIV_OP_REMU);

  always_comb begin
    early_hit = 1'b1;
    if (src_b == '0) begin
      early_res = is_rem_in ? src_a : '1;
    end else if (signed_op && (src_a == {1'b1, {(WIDTH-1){1'b0}}}) && (src_b == '1)) begin
      early_res = is_rem_in ? '0 : src_a;
    end else if (abs_a < abs_b) begin
      early_res = is_rem_in ? src_a : '0;
    end else begin
      early_hit = 1'b0;
      early_res = '0;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    res_d   = res_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        // done_q marks the completion cycle, which still counts as busy.
        if (start && !done_q) begin
          op_d    = op_in;
          quo_d   = abs_a;
          div_d   = abs_b;
          rem_d   = '0;
          // Divide by zero keeps an unsigned all-ones quotient.
          negq_d  = (op_in == DIV_OP_DIV) && (sign_a ^ sign_b) && (src_b != '0);
          negr_d  = (op_in == DIV_OP_REM) && sign_a;
          cnt_d   = CNT_W'(WIDTH);
          state_d = S_CALC;
`ifdef RISCV_DIV_EARLY_OUT_EN
          if (early_hit) begin
            res_d   = early_res;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
`endif
        end
      end
      S_CALC: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) state_d = S_FIX;
      end
      S_FIX: begin
        res_d   = is_rem_q ? rem_fix : quo_fix;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (flush) begin
      state_d = S_IDLE;
      done_d  = 1'b0;
      res_d   = res_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= DIV_OP_DIV;
      rem_q   <= '0;
      quo_q   <= '0;
      div_q   <= '0;
      cnt_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      res_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      res_q   <= res_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q != S_IDLE) || done_q;
  assign done = done_q;
  assign res  = res_q;

endmodule

// File: tb/tb_riscv_div_iter.sv
// tb_riscv_div_iter: directed self-checking bench for riscv_div_iter.
// Build with RISCV_DIV_EARLY_OUT_EN defined to expect short latency on
// special-case operands.
module tb_riscv_div_iter;
  import riscv_div_pkg::*;

  localparam int W = 32;
  localparam int NORMAL_LAT = W + 1;
`ifdef RISCV_DIV_EARLY_OUT_EN
  localparam int SPECIAL_LAT = 0;
`else
  localparam int SPECIAL_LAT = W + 1;
`endif

  logic         clk = 1'b0;
  logic         rst_n, start, flush, busy, done;
  logic [1:0]   op;
  logic [W-1:0] src_a, src_b, res;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  riscv_div_iter #(.WIDTH(W), .CNT_W(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .src_a (src_a),
    .src_b (src_b),
    .flush (flush),
    .busy  (busy),
    .done  (done),
    .res   (res)
  );

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Present a request for one cycle; returns 1ns after the accepting edge.
  task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    op = o; src_a = a; src_b = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Count edges after the accepting edge until done, bounded.
  task automatic wait_done(input int lat0, output int lat);
    lat = lat0;
    while (done !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic finish_check(input string tag, input int lat, input int exp_lat,
                              input logic [W-1:0] exp);
    check({tag, " done"}, {31'b0, done}, 1);
    check({tag, " latency"}, W'(lat), W'(exp_lat));
    check({tag, " res"}, res, exp);
    check({tag, " busy@done"}, {31'b0, busy}, 1);
    @(posedge clk); #1;
    check({tag, " done pulse"}, {31'b0, done}, 0);
    check({tag, " busy end"}, {31'b0, busy}, 0);
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] exp, input int exp_lat);
    int lat;
    issue(o, a, b);
    check({tag, " busy"}, {31'b0, busy}, 1);
    wait_done(0, lat);
    finish_check(tag, lat, exp_lat, exp);
  endtask

  initial begin
    int lat;
    int seen;
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = 2'b00; src_a = '0; src_b = '0;
    #12;
    check("reset busy", {31'b0, busy}, 0);
    check("reset done", {31'b0, done}, 0);
    check("reset res", res, '0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("divu 100/7", DIV_OP_DIVU, 32'd100, 32'd7, 32'd14, NORMAL_LAT);
    run_op("remu 100/7", DIV_OP_REMU, 32'd100, 32'd7, 32'd2, NORMAL_LAT);
    run_op("div -100/7", DIV_OP_DIV, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, NORMAL_LAT);
    run_op("rem -100/7", DIV_OP_REM, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, NORMAL_LAT);
    run_op("div by 0", DIV_OP_DIV, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, SPECIAL_LAT);
    run_op("remu by 0", DIV_OP_REMU, 32'h1234_5678, 32'd0, 32'h1234_5678, SPECIAL_LAT);
    run_op("div ovf", DIV_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, SPECIAL_LAT);

    // Flush at cycle 10: aborted op leaves res at the previous result.
    issue(DIV_OP_DIVU, 32'd50, 32'd5);
    repeat (9) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush busy", {31'b0, busy}, 0);
    check("flush done", {31'b0, done}, 0);
    check("flush res", res, 32'h8000_0000);
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    check("flush no done", W'(seen), 0);
    run_op("divu 50/5", DIV_OP_DIVU, 32'd50, 32'd5, 32'd10, NORMAL_LAT);

    run_op("rem ovf", DIV_OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, SPECIAL_LAT);

    // A second start while busy is ignored; first result returned on time.
    issue(DIV_OP_DIVU, 32'd100, 32'd7);
    repeat (5) begin @(posedge clk); #1; end
    op = DIV_OP_REMU; src_a = 32'd50; src_b = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(6, lat);
    finish_check("ignored start", lat, NORMAL_LAT, 32'd14);

    // Asynchronous reset mid-operation.
    issue(DIV_OP_DIVU, 32'd100, 32'd7);
    repeat (20) begin @(posedge clk); #1; end
    check("pre-reset busy", {31'b0, busy}, 1);
    rst_n = 1'b0;
    #1;
    check("async rst busy", {31'b0, busy}, 0);
    check("async rst done", {31'b0, done}, 0);
    check("async rst res", res, '0);
    #2 rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    check("rst no done", W'(seen), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
